// File: rtl/hack_soc_pkg.sv
// Shared definitions for the VRAM arbitration path: default bus widths,
// memory FSM state encoding and access owner encoding.
package hack_soc_pkg;

  localparam int unsigned ADDR_W_DEFAULT         = 13;
  localparam int unsigned DATA_W_DEFAULT         = 16;
  localparam int unsigned MAX_DISP_BURST_DEFAULT = 4;

  // Memory-side FSM: one access at a time, always followed by a response cycle
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Who the in-flight memory access belongs to
  typedef enum logic [1:0] {
    OWN_DISP   = 2'd0,
    OWN_CPU_RD = 2'd1,
    OWN_DRAIN  = 2'd2
  } owner_e;

endpackage

// File: rtl/vram_write_buffer.sv
// One-entry posted write buffer for the CPU port.
// Ports:
//   clk, reset      clock, async active-high reset
//   wr_req          CPU write waiting to be posted (already ack-qualified)
//   wr_addr/wr_data write address and data to capture
//   drain_done      buffered write completes at memory on this edge
//   lookup_addr     CPU read address for the hit compare
//   wb_valid/wb_addr/wb_data  buffer contents
//   cap_c           write is captured on this edge
//   hit_c           lookup_addr matches a valid buffered write
module vram_write_buffer
  import hack_soc_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              drain_done,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              cap_c,
  output logic              hit_c
);

  // The entry frees up on the drain-completion edge, so a waiting write may
  // land on that very edge; the new write then keeps the entry valid.
  assign cap_c = wr_req && (!wb_valid || drain_done);
  assign hit_c = wb_valid && (wb_addr == lookup_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else if (cap_c) begin
      wb_valid <= 1'b1;
      wb_addr  <= wr_addr;
      wb_data  <= wr_data;
    end else if (drain_done) begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates a display read port and a CPU read/write port onto a single
// QSPI VRAM controller interface. CPU writes are posted through a one-entry
// buffer; display reads win unless they have starved the CPU side for
// MAX_DISP_BURST consecutive grants.
// Ports:
//   clk, reset                              clock, async active-high reset
//   disp_req/disp_addr -> disp_ack/disp_rdata     display read port
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_ack/cpu_rdata  CPU port
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_done  memory controller
module vram_arbiter
  import hack_soc_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W         = DATA_W_DEFAULT,
  parameter int unsigned MAX_DISP_BURST = MAX_DISP_BURST_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done
);

  localparam int unsigned STREAK_W = $clog2(MAX_DISP_BURST + 1);

  mem_state_e          state_q;
  owner_e              owner_q;
  logic [STREAK_W-1:0] streak_q;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_cap_c;
  logic              wb_hit_c;

  logic drain_done_c;
  logic cpu_free_c;
  logic wr_req_c;
  logic rd_c;
  logic rd_hit_c;
  logic rd_miss_c;
  logic cpu_item_c;
  logic disp_pend_c;
  logic burst_full_c;

  // A request whose ack is showing this cycle has already been served
  assign cpu_free_c   = cpu_req && !cpu_ack;
  assign wr_req_c     = cpu_free_c && cpu_we;
  assign rd_c         = cpu_free_c && !cpu_we;
  assign rd_hit_c     = rd_c && wb_hit_c;
  // Reads that miss a valid buffer wait behind its drain, so only count as a
  // memory read once the buffer is empty
  assign rd_miss_c    = rd_c && !wb_valid;
  assign cpu_item_c   = wb_valid || rd_miss_c;
  assign disp_pend_c  = disp_req && !disp_ack;
  assign burst_full_c = (streak_q == STREAK_W'(MAX_DISP_BURST));
  assign drain_done_c = (state_q == ST_MEM) && mem_done && (owner_q == OWN_DRAIN);

  vram_write_buffer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_write_buffer (
    .clk        (clk),
    .reset      (reset),
    .wr_req     (wr_req_c),
    .wr_addr    (cpu_addr),
    .wr_data    (cpu_wdata),
    .drain_done (drain_done_c),
    .lookup_addr(cpu_addr),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .cap_c      (wb_cap_c),
    .hit_c      (wb_hit_c)
  );

  // Memory FSM, arbitration, streak tracking and registered port outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_DISP;
      streak_q   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      disp_ack   <= 1'b0;
      disp_rdata <= '0;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      disp_ack <= 1'b0;
      cpu_ack  <= 1'b0;

      // Posted writes and buffer hits are answered independently of the FSM
      if (wb_cap_c) begin
        cpu_ack <= 1'b1;
      end
      if (rd_hit_c) begin
        cpu_ack   <= 1'b1;
        cpu_rdata <= wb_data;
      end

      case (state_q)
        ST_IDLE: begin
          if (cpu_item_c && (!disp_pend_c || burst_full_c)) begin
            state_q  <= ST_MEM;
            mem_req  <= 1'b1;
            streak_q <= '0;
            if (wb_valid) begin
              owner_q   <= OWN_DRAIN;
              mem_we    <= 1'b1;
              mem_addr  <= wb_addr;
              mem_wdata <= wb_data;
            end else begin
              owner_q   <= OWN_CPU_RD;
              mem_we    <= 1'b0;
              mem_addr  <= cpu_addr;
              mem_wdata <= '0;
            end
          end else if (disp_pend_c) begin
            state_q   <= ST_MEM;
            owner_q   <= OWN_DISP;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= disp_addr;
            mem_wdata <= '0;
            if (!cpu_item_c) begin
              streak_q <= '0;
            end else if (!burst_full_c) begin
              streak_q <= streak_q + STREAK_W'(1);
            end
          end else begin
            streak_q <= '0;
          end
        end

        ST_MEM: begin
          if (!cpu_item_c) begin
            streak_q <= '0;
          end
          if (mem_done) begin
            state_q <= ST_RESP;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            case (owner_q)
              OWN_DISP: begin
                disp_ack   <= 1'b1;
                disp_rdata <= mem_rdata;
              end
              OWN_CPU_RD: begin
                cpu_ack   <= 1'b1;
                cpu_rdata <= mem_rdata;
              end
              default: ;
            endcase
          end
        end

        ST_RESP: begin
          // Guaranteed idle cycle between memory accesses
          state_q <= ST_IDLE;
          if (!cpu_item_c) begin
            streak_q <= '0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a latency-programmable memory model,
// scoreboards for memory accesses and per-port acks, and one task per scenario.
module tb_vram_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_ack;
  logic [DW-1:0] disp_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } mem_exp_t;

  typedef struct packed {
    logic          is_rd;
    logic [DW-1:0] data;
  } cpu_exp_t;

  mem_exp_t      exp_mem_q[$];
  logic [DW-1:0] exp_disp_q[$];
  cpu_exp_t      exp_cpu_q[$];
  bit            ack_order[$];
  logic [DW-1:0] mem_model [8192];

  int n_checks;
  int n_pass;
  int cyc;
  int mem_cnt;
  int mem_lat;
  int n_mem_acc;
  int req_run;
  int last_req_len;
  int done_cyc;
  int disp_ack_cyc;
  int cpu_ack_cyc;
  bit mem_en;
  bit disp_hold;

  vram_arbiter #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .MAX_DISP_BURST(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_ack  (disp_ack),
    .disp_rdata(disp_rdata),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done)
  );

  always #5 clk = ~clk;

  function automatic mem_exp_t mk_mem(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_exp_t e;
    e.we = we; e.addr = a; e.data = d;
    return e;
  endfunction

  function automatic cpu_exp_t mk_cpu(input logic is_rd, input logic [DW-1:0] d);
    cpu_exp_t c;
    c.is_rd = is_rd; c.data = d;
    return c;
  endfunction

  // One clock: memory model response plus ack scoreboards, sampled 1 after the edge
  task automatic tick();
    mem_exp_t      e;
    cpu_exp_t      c;
    logic [DW-1:0] d;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_req) req_run++;
    else if (req_run != 0) begin last_req_len = req_run; req_run = 0; end
    if (mem_en) begin
      if (mem_done) begin
        mem_done = 1'b0;
        mem_cnt  = 0;
      end else if (mem_req) begin
        mem_cnt++;
        if (mem_cnt == mem_lat) begin
          n_mem_acc++;
          done_cyc = cyc;
          n_checks++;
          if (exp_mem_q.size() == 0) begin
            $display("FAIL mem_access: got we=%0b addr=%h wdata=%h, required no access", mem_we, mem_addr, mem_wdata);
          end else begin
            e = exp_mem_q.pop_front();
            if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data))
              $display("FAIL mem_access: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                       mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
            else n_pass++;
          end
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else mem_rdata = mem_model[mem_addr];
          mem_done = 1'b1;
        end
      end else begin
        mem_cnt = 0;
      end
    end
    if (disp_ack) begin
      disp_ack_cyc = cyc;
      ack_order.push_back(1'b1);
      n_checks++;
      if (exp_disp_q.size() == 0) begin
        $display("FAIL disp_ack: got unexpected ack rdata=%h, required no ack", disp_rdata);
      end else begin
        d = exp_disp_q.pop_front();
        if (disp_rdata !== d) $display("FAIL disp_rdata: got %h, required %h", disp_rdata, d);
        else n_pass++;
      end
      if (!disp_hold) disp_req = 1'b0;
    end
    if (cpu_ack) begin
      cpu_ack_cyc = cyc;
      ack_order.push_back(1'b0);
      n_checks++;
      if (exp_cpu_q.size() == 0) begin
        $display("FAIL cpu_ack: got unexpected ack rdata=%h, required no ack", cpu_rdata);
      end else begin
        c = exp_cpu_q.pop_front();
        if (cpu_we !== !c.is_rd) $display("FAIL cpu_ack_kind: got we=%0b, required we=%0b", cpu_we, !c.is_rd);
        else if (c.is_rd && cpu_rdata !== c.data) $display("FAIL cpu_rdata: got %h, required %h", cpu_rdata, c.data);
        else n_pass++;
      end
      cpu_req = 1'b0;
    end
  endtask

  // Runs until every expectation is consumed and the DUT is idle
  task automatic run_quiet(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (exp_mem_q.size() == 0 && exp_disp_q.size() == 0 && exp_cpu_q.size() == 0 &&
          !mem_req && !mem_done && !disp_ack && !cpu_ack) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, disp_ack, cpu_ack, disp_rdata, cpu_rdata} !== '0)
      $display("FAIL reset_async: got req=%0b we=%0b addr=%h wdata=%h acks=%0b%0b, required all zero",
               mem_req, mem_we, mem_addr, mem_wdata, disp_ack, cpu_ack);
    else n_pass++;
    disp_req = 1'b1; disp_addr = 13'h0ABC; cpu_req = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({mem_req, disp_ack, cpu_ack} !== 3'b000)
      $display("FAIL reset_held: got req=%0b acks=%0b%0b, required 0", mem_req, disp_ack, cpu_ack);
    else n_pass++;
    disp_req = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_disp_read();
    bit got = 1'b0;
    mem_lat = 3;
    mem_model[13'h0100] = 16'hBEEF;
    exp_mem_q.push_back(mk_mem(1'b0, 13'h0100, 16'h0000));
    exp_disp_q.push_back(16'hBEEF);
    disp_addr = 13'h0100; disp_req = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin tick(); if (disp_ack) got = 1'b1; end
    n_checks++;
    if (!got) $display("FAIL disp_read_timeout: got no ack, required ack"); else n_pass++;
    n_checks++;
    if (last_req_len !== 3) $display("FAIL disp_mem_req_len: got %0d, required 3", last_req_len); else n_pass++;
    n_checks++;
    if (disp_ack_cyc - done_cyc !== 1) $display("FAIL disp_ack_latency: got %0d, required 1", disp_ack_cyc - done_cyc);
    else n_pass++;
    tick();
  endtask

  task automatic test_posted_write();
    bit got;
    bit ok;
    int start;
    int acc0 = n_mem_acc;
    mem_lat = 3;
    exp_mem_q.push_back(mk_mem(1'b0, 13'h0200, 16'h0000));
    exp_disp_q.push_back(mem_model[13'h0200]);
    exp_mem_q.push_back(mk_mem(1'b1, 13'h1FFF, 16'h1234));
    exp_cpu_q.push_back(mk_cpu(1'b0, 16'h0000));
    exp_cpu_q.push_back(mk_cpu(1'b1, 16'h1234));
    disp_addr = 13'h0200; disp_req = 1'b1;
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 13'h0200) $display("FAIL disp_in_flight: got req=%0b addr=%h, required 1/0200", mem_req, mem_addr);
    else n_pass++;
    cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 16'h1234; cpu_req = 1'b1;
    start = cyc; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin tick(); if (cpu_ack) got = 1'b1; end
    n_checks++;
    if (!got || cpu_ack_cyc - start !== 1) $display("FAIL posted_write_latency: got %0d, required 1", cpu_ack_cyc - start);
    else n_pass++;
    tick();
    cpu_we = 1'b0; cpu_addr = 13'h1FFF; cpu_req = 1'b1;
    start = cyc; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin tick(); if (cpu_ack) got = 1'b1; end
    n_checks++;
    if (!got || cpu_ack_cyc - start !== 1) $display("FAIL read_hit_latency: got %0d, required 1", cpu_ack_cyc - start);
    else n_pass++;
    run_quiet(50, ok);
    n_checks++;
    if (!ok) $display("FAIL posted_write_drain: got pending work, required idle"); else n_pass++;
    n_checks++;
    if (n_mem_acc - acc0 !== 2) $display("FAIL posted_write_accesses: got %0d, required 2", n_mem_acc - acc0);
    else n_pass++;
  endtask

  task automatic test_burst();
    bit ok;
    bit exp_ord[6];
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    mem_lat = 2;
    ack_order.delete();
    for (int i = 0; i < 4; i++) begin
      exp_mem_q.push_back(mk_mem(1'b0, 13'h0300, 16'h0000));
      exp_disp_q.push_back(mem_model[13'h0300]);
    end
    exp_mem_q.push_back(mk_mem(1'b0, 13'h0400, 16'h0000));
    exp_cpu_q.push_back(mk_cpu(1'b1, mem_model[13'h0400]));
    exp_mem_q.push_back(mk_mem(1'b0, 13'h0300, 16'h0000));
    exp_disp_q.push_back(mem_model[13'h0300]);
    disp_hold = 1'b1; disp_addr = 13'h0300; disp_req = 1'b1;
    cpu_we = 1'b0; cpu_addr = 13'h0400; cpu_req = 1'b1;
    for (int i = 0; i < 200 && ack_order.size() < 6; i++) tick();
    disp_hold = 1'b0; disp_req = 1'b0;
    n_checks++;
    if (ack_order.size() !== 6) $display("FAIL burst_ack_count: got %0d, required 6", ack_order.size());
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (i < ack_order.size()) begin
        n_checks++;
        if (ack_order[i] !== exp_ord[i]) $display("FAIL burst_order[%0d]: got disp=%0b, required disp=%0b", i, ack_order[i], exp_ord[i]);
        else n_pass++;
      end
    end
    run_quiet(50, ok);
    n_checks++;
    if (!ok) $display("FAIL burst_quiet: got pending work, required idle"); else n_pass++;
  endtask

  task automatic test_same_edge();
    bit got;
    bit ok;
    mem_lat = 3;
    exp_mem_q.push_back(mk_mem(1'b1, 13'h0010, 16'h1111));
    exp_mem_q.push_back(mk_mem(1'b1, 13'h0020, 16'h2222));
    exp_mem_q.push_back(mk_mem(1'b0, 13'h0010, 16'h0000));
    exp_cpu_q.push_back(mk_cpu(1'b0, 16'h0000));
    exp_cpu_q.push_back(mk_cpu(1'b0, 16'h0000));
    exp_cpu_q.push_back(mk_cpu(1'b1, 16'h1111));
    cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 16'h1111; cpu_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin tick(); if (cpu_ack) got = 1'b1; end
    tick();
    cpu_we = 1'b1; cpu_addr = 13'h0020; cpu_wdata = 16'h2222; cpu_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); if (cpu_ack) got = 1'b1; end
    n_checks++;
    if (!got || cpu_ack_cyc - done_cyc !== 1)
      $display("FAIL same_edge_capture: got ack %0d cycles after drain done, required 1", cpu_ack_cyc - done_cyc);
    else n_pass++;
    tick();
    cpu_we = 1'b0; cpu_addr = 13'h0010; cpu_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin tick(); if (cpu_ack) got = 1'b1; end
    n_checks++;
    if (!got) $display("FAIL read_after_drain_timeout: got no ack, required ack"); else n_pass++;
    run_quiet(50, ok);
    n_checks++;
    if (!ok) $display("FAIL same_edge_quiet: got pending work, required idle"); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit got = 1'b0;
    mem_en = 1'b0; mem_done = 1'b0; mem_cnt = 0;
    disp_addr = 13'h0500; disp_req = 1'b1;
    tick();
    exp_cpu_q.push_back(mk_cpu(1'b0, 16'h0000));
    cpu_we = 1'b1; cpu_addr = 13'h0055; cpu_wdata = 16'hAAAA; cpu_req = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin tick(); if (cpu_ack) got = 1'b1; end
    n_checks++;
    if (!got || mem_req !== 1'b1) $display("FAIL reset_mid_setup: got ack=%0b req=%0b, required 1/1", got, mem_req);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, disp_ack, cpu_ack, disp_rdata, cpu_rdata} !== '0)
      $display("FAIL reset_mid_async: got req=%0b addr=%h acks=%0b%0b disp_rdata=%h, required all zero",
               mem_req, mem_addr, disp_ack, cpu_ack, disp_rdata);
    else n_pass++;
    disp_req = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_done = (i % 2 == 0);
      tick();
      n_checks++;
      if ({mem_req, disp_ack, cpu_ack} !== 3'b000)
        $display("FAIL after_reset_idle[%0d]: got req=%0b acks=%0b%0b, required 0", i, mem_req, disp_ack, cpu_ack);
      else n_pass++;
    end
    mem_done = 1'b0; mem_cnt = 0; mem_en = 1'b1;
  endtask

  initial begin
    reset = 1'b0; disp_req = 1'b0; disp_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0; mem_done = 1'b0;
    n_checks = 0; n_pass = 0; cyc = 0; mem_cnt = 0; mem_lat = 3; n_mem_acc = 0;
    req_run = 0; last_req_len = 0; done_cyc = 0; disp_ack_cyc = 0; cpu_ack_cyc = 0;
    mem_en = 1'b1; disp_hold = 1'b0;
    for (int i = 0; i < 8192; i++) mem_model[i] = 16'(i) ^ 16'hA5A5;
    test_reset();
    test_disp_read();
    test_posted_write();
    test_burst();
    test_same_edge();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 13, word address width (8192-word screen).
REQ-002 SHALL have parameter DATA_W, 16, word width.
REQ-003 SHALL have parameter MAX_DISP_BURST, 4, consecutive display grants allowed while a CPU-side item is pending.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports disp_req in 1, disp_addr in ADDR_W, disp_ack out 1, disp_rdata out DATA_W: display read port.
REQ-007 SHALL have ports cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W, cpu_ack out 1, cpu_rdata out DATA_W: CPU read/write port.
REQ-008 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W, mem_done in 1: toward the QSPI VRAM controller.

Function
REQ-009 Requesters SHALL hold req and all request fields stable until ack; ack SHALL be a registered single-cycle pulse; req SHALL be low in the cycle after ack.
REQ-010 Read data SHALL be valid on disp_rdata/cpu_rdata in the ack cycle and held until the next ack on that port.
REQ-011 SHALL contain a one-entry posted write buffer (wb_valid, wb_addr, wb_data).
REQ-012 CPU write with wb_valid=0: SHALL capture addr/data on the first edge with cpu_req&cpu_we, and assert cpu_ack in the next cycle (latency 1), independent of the memory FSM state.
REQ-013 CPU write with wb_valid=1: SHALL stall (no ack) until the buffer drains, then apply REQ-012.
REQ-014 CPU read hitting wb_addr while wb_valid=1 SHALL be answered from wb_data with cpu_ack one cycle later, without a memory access.
REQ-015 CPU read missing the buffer while wb_valid=1 SHALL wait for the drain (write-before-read ordering).
REQ-016 Memory FSM states: IDLE, MEM, RESP.
REQ-017 IDLE: choose among display read, buffer drain (wb_valid), and CPU read miss (wb_valid=0); SHALL go to MEM on the next edge with mem_req=1 and registered fields.
REQ-018 Priority SHALL be display first, unless streak==MAX_DISP_BURST and a CPU-side item is pending. CPU side SHALL order drain before read.
REQ-019 streak SHALL increment (saturating) on each display grant made while a CPU-side item is pending, and SHALL clear on any CPU-side grant or when no CPU-side item is pending.
REQ-020 MEM: mem_req and its fields SHALL be held stable until mem_done=1; on that edge, capture mem_rdata, drop mem_req and go to RESP. A drain SHALL clear wb_valid on that edge.
REQ-021 RESP: pulse the owner's ack (no ack for a drain) and return to IDLE; SHALL NOT issue a new mem_req in RESP (minimum one idle cycle between accesses).
REQ-022 mem_done outside MEM SHALL be ignored.
REQ-023 If a buffer capture and a drain completion fall on the same edge, the capture SHALL win and wb_valid SHALL remain 1.
REQ-024 Address SHALL pass through unmodified, with no wrap logic; address ADDR_W'h1FFF is legal.

Reset
REQ-025 While reset=1, state=IDLE, streak=0, wb_valid=0, and all outputs (mem_req, mem_we, mem_addr, mem_wdata, acks, rdata) SHALL be 0 immediately, without waiting for clk.
REQ-026 Reset mid-access SHALL abandon the access; a pending posted write SHALL be discarded.

Structure
REQ-027 A shared package/include (hack_soc_pkg) SHALL hold the FSM state encoding, the ADDR_W/DATA_W defaults and the owner encoding (DISP, CPU_RD, DRAIN).
REQ-028 The posted write buffer, including hit compare and same-edge rule, SHALL be one sub-module: vram_write_buffer.

Verification
REQ-029 Display read 0x0100, mem_done 3 cycles after mem_req, mem_rdata=0xBEEF -> disp_ack one cycle after mem_done with disp_rdata=0xBEEF; mem_req high exactly 3 cycles.
REQ-030 CPU write 0x1FFF=0x1234 while display access in flight -> cpu_ack after 1 cycle; the drain issues after the display RESP with mem_we=1, mem_addr=0x1FFF and mem_wdata=0x1234.
REQ-031 CPU read 0x1FFF immediately after that write, before the drain -> cpu_rdata=0x1234, no mem_req issued for the read.
REQ-032 disp_req held continuously with a CPU read pending, MAX_DISP_BURST=4 -> exactly 4 display grants, then the CPU read grant, then display resumes.
REQ-033 Assert reset during MEM with wb_valid=1 -> mem_req=0 and all acks 0 before the next clk edge; after release, no drain occurs and mem_done pulses are ignored.
REQ-034 Buffer capture coincident with drain completion -> wb_valid stays 1 and the second write reaches memory.
